// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory read port and one write port among NUM_REQ requesters.
// After reset, an optional sequencer zero-fills the memory before any request is served.
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 1024,
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned INIT_ZERO  = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0]                   req_we,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                   resp_valid,
  output logic [NUM_REQ-1:0]                   resp_err,
  output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   resp_data,
  output logic [ADDR_WIDTH-1:0]                mem_read_addr,
  output logic                                 mem_read_enable,
  input  logic [DATA_WIDTH-1:0]                mem_read_data,
  output logic [ADDR_WIDTH-1:0]                mem_write_addr,
  output logic [DATA_WIDTH-1:0]                mem_write_data,
  output logic                                 mem_write_enable,
  output logic                                 init_done
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ST_INIT, ST_SERVE} state_e;

  state_e                              state_q, state_d;
  logic [ADDR_WIDTH-1:0]               init_cnt_q, init_cnt_d;
  logic                                init_done_q, init_done_d;
  logic [PTR_W-1:0]                    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]                  resp_valid_q, resp_valid_d;
  logic [NUM_REQ-1:0]                  resp_err_q, resp_err_d;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  resp_data_q, resp_data_d;

  logic                                grant_vld;
  logic [PTR_W-1:0]                    grant_idx;
  logic [PTR_W:0]                      cand;
  logic [ADDR_WIDTH-1:0]               sel_addr;
  logic                                sel_in_range;

  // Search starts at rr_ptr and wraps; first valid requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!grant_vld && req_valid[cand[PTR_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
  end

  assign sel_addr     = req_addr[grant_idx];
  assign sel_in_range = 64'(sel_addr) < 64'(MEM_SIZE);

  always_comb begin
    state_d          = state_q;
    init_cnt_d       = init_cnt_q;
    init_done_d      = init_done_q | (INIT_ZERO == 0);
    rr_ptr_d         = rr_ptr_q;
    resp_valid_d     = '0;
    resp_err_d       = '0;
    resp_data_d      = resp_data_q;
    req_ready        = '0;
    mem_read_addr    = '0;
    mem_read_enable  = 1'b0;
    mem_write_addr   = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    // Nothing is granted or written while reset is held, so an in-flight request is dropped.
    if (reset) begin
      case (state_q)
        ST_INIT: begin
          mem_write_enable = 1'b1;
          mem_write_addr   = init_cnt_q;
          init_cnt_d       = init_cnt_q + 1'b1;
          if (init_cnt_q == ADDR_WIDTH'(MEM_SIZE - 1)) begin
            state_d     = ST_SERVE;
            init_done_d = 1'b1;
          end
        end
        ST_SERVE: begin
          if (grant_vld) begin
            req_ready[grant_idx]    = 1'b1;
            rr_ptr_d                = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            resp_valid_d[grant_idx] = 1'b1;
            if (!sel_in_range) begin
              resp_err_d[grant_idx] = 1'b1;
              if (!req_we[grant_idx]) resp_data_d[grant_idx] = '0;
            end else if (req_we[grant_idx]) begin
              mem_write_enable = 1'b1;
              mem_write_addr   = sel_addr;
              mem_write_data   = req_wdata[grant_idx];
            end else begin
              mem_read_enable        = 1'b1;
              mem_read_addr          = sel_addr;
              resp_data_d[grant_idx] = mem_read_data;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= (INIT_ZERO != 0) ? ST_INIT : ST_SERVE;
      init_cnt_q   <= '0;
      init_done_q  <= 1'b0;
      rr_ptr_q     <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      init_done_q  <= init_done_d;
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_data_q;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked against
// a behavioural model (round-robin order, expected memory contents, per-requester responses).
module tb_mem_port_arbiter;
  localparam int N  = 2;
  localparam int MS = 16;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [N-1:0]         req_valid = '0;
  logic [N-1:0]         req_ready;
  logic [N-1:0]         req_we = '0;
  logic [N-1:0][AW-1:0] req_addr = '0;
  logic [N-1:0][DW-1:0] req_wdata = '0;
  logic [N-1:0]         resp_valid;
  logic [N-1:0]         resp_err;
  logic [N-1:0][DW-1:0] resp_data;
  logic [AW-1:0]        mem_read_addr;
  logic                 mem_read_enable;
  logic [DW-1:0]        mem_read_data;
  logic [AW-1:0]        mem_write_addr;
  logic [DW-1:0]        mem_write_data;
  logic                 mem_write_enable;
  logic                 init_done;

  mem_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS), .NUM_REQ(N), .INIT_ZERO(1)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_data(resp_data),
    .mem_read_addr(mem_read_addr), .mem_read_enable(mem_read_enable),
    .mem_read_data(mem_read_data),
    .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Attached memory array; nonzero power-up contents expose a missing zero-fill.
  logic [DW-1:0] mem [MS] = '{default: 32'hA5A5_5A5A};
  always @(posedge clk)
    if (mem_write_enable && mem_write_addr < MS) mem[mem_write_addr[3:0]] <= mem_write_data;
  assign mem_read_data = (mem_read_enable && mem_read_addr < MS) ? mem[mem_read_addr[3:0]] : '0;

  // Reference model state
  int            rr;
  logic [N-1:0]  ev, ee;
  logic [DW-1:0] ed [N];
  logic [DW-1:0] rmem [MS];
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rr = 0; ev = '0; ee = '0;
    for (int i = 0; i < N; i++) ed[i] = '0;
  endtask

  // Hold reset for one edge with the given read requests presented (they must be dropped).
  task automatic apply_reset(input logic [N-1:0] v);
    reset = 1'b0; req_valid = v; req_we = '0; req_addr[0] = 5; req_addr[1] = 5;
    @(posedge clk); #1;
    chk("rst_resp_valid", resp_valid, '0);
    chk("rst_resp_err", resp_err, '0);
    chk("rst_resp_data0", resp_data[0], '0);
    chk("rst_resp_data1", resp_data[1], '0);
    chk("rst_init_done", init_done, 0);
    model_reset();
  endtask

  task automatic run_init(input int n);
    reset = 1'b1; req_valid = '1; req_we = '1;
    for (int i = 0; i < n; i++) begin
      req_addr[0] = $urandom_range(MS - 1, 0); req_addr[1] = $urandom_range(MS - 1, 0);
      #1;
      chk("init_we", mem_write_enable, 1);
      chk("init_waddr", mem_write_addr, i);
      chk("init_wdata", mem_write_data, 0);
      chk("init_re", mem_read_enable, 0);
      chk("init_ready", req_ready, '0);
      chk("init_done_low", init_done, 0);
      @(posedge clk); #1;
    end
    req_valid = '0;
    if (n == MS) begin
      chk("init_done_high", init_done, 1);
      for (int i = 0; i < MS; i++) rmem[i] = '0;
    end
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] we,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    logic [AW-1:0] a [N];
    logic [DW-1:0] d [N];
    logic [N-1:0]  er;
    int g, gi;
    bit inr, wr, rd;
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    req_valid = v; req_we = we;
    req_addr[0] = a0; req_addr[1] = a1; req_wdata[0] = d0; req_wdata[1] = d1;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) if (g < 0 && v[(rr + k) % N]) g = (rr + k) % N;
    gi = (g < 0) ? 0 : g;
    er = '0;
    if (g >= 0) er[gi] = 1'b1;
    inr = a[gi] < MS;
    wr  = (g >= 0) && inr && we[gi];
    rd  = (g >= 0) && inr && !we[gi];
    chk("req_ready", req_ready, er);
    chk("mem_write_enable", mem_write_enable, wr);
    chk("mem_write_addr", mem_write_addr, wr ? a[gi] : '0);
    chk("mem_write_data", mem_write_data, wr ? d[gi] : '0);
    chk("mem_read_enable", mem_read_enable, rd);
    chk("mem_read_addr", mem_read_addr, rd ? a[gi] : '0);
    ev = '0; ee = '0;
    if (g >= 0) begin
      ev[gi] = 1'b1;
      ee[gi] = !inr;
      if (!we[gi]) ed[gi] = inr ? rmem[a[gi]] : '0;
      else if (inr) rmem[a[gi]] = d[gi];
      rr = (g + 1) % N;
    end
    @(posedge clk); #1;
    chk("resp_valid", resp_valid, ev);
    chk("resp_err", resp_err, ee);
    chk("resp_data0", resp_data[0], ed[0]);
    chk("resp_data1", resp_data[1], ed[1]);
  endtask

  initial begin
    // Reset mid-zero-fill at counter 7, then a full restart from address 0.
    apply_reset('0);
    run_init(7);
    apply_reset('0);
    run_init(MS);

    // Write then read-back on requester 0.
    cycle(2'b01, 2'b01, 5, 0, 32'hDEAD_BEEF, 0);
    cycle(2'b01, 2'b00, 5, 0, 0, 0);
    chk("deadbeef_read", resp_data[0], 32'hDEAD_BEEF);

    // Reset in the acceptance cycle of a read: response dropped, data cleared.
    apply_reset(2'b01);
    run_init(MS);

    // Seed addr 1/2, then both requesters continuously reading: grants alternate 0,1,...
    cycle(2'b01, 2'b01, 1, 0, 32'h1111_1111, 0);
    cycle(2'b10, 2'b10, 0, 2, 0, 32'h2222_2222);
    for (int i = 0; i < 6; i++) begin
      cycle(2'b11, 2'b00, 1, 2, 0, 0);
      chk("alt_grant", resp_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    chk("alt_data1", resp_data[1], 32'h2222_2222);

    // Address range boundaries on requester 1.
    cycle(2'b10, 2'b00, 0, MS, 0, 0);
    chk("oor_err", resp_err, 2'b10);
    cycle(2'b10, 2'b10, 0, MS + 1, 0, 32'hFFFF_FFFF);
    cycle(2'b10, 2'b10, 0, MS - 1, 0, 32'h0BAD_CAFE);
    cycle(2'b10, 2'b00, 0, MS - 1, 0, 0);
    chk("last_word", resp_data[1], 32'h0BAD_CAFE);

    // Random mixed traffic including out-of-range addresses and idle cycles.
    for (int i = 0; i < 300; i++)
      cycle(N'($urandom), N'($urandom),
            $urandom_range(MS + 1, 0), $urandom_range(MS + 1, 0), $urandom, $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
